// File: rtl/bot_input_sequencer_if.sv
// Signal bundle between the player-1 decode / bot control side (master) and the
// bot input sequencer (slave). Clock and reset stay outside as plain ports.
interface bot_input_sequencer_if;
  logic       enable;
  logic [1:0] mode;
  logic [1:0] difficulty;
  logic       p1_input_valid;
  logic       p1_left;
  logic       p1_right;
  logic       p1_attack;
  logic       bot_left;
  logic       bot_right;
  logic       bot_attack;
  logic       bot_busy;
  logic       trig_drop;
  logic [6:0] frame_value;

  modport master (
    output enable, mode, difficulty, p1_input_valid, p1_left, p1_right, p1_attack,
    input  bot_left, bot_right, bot_attack, bot_busy, trig_drop, frame_value
  );

  modport slave (
    input  enable, mode, difficulty, p1_input_valid, p1_left, p1_right, p1_attack,
    output bot_left, bot_right, bot_attack, bot_busy, trig_drop, frame_value
  );
endinterface

// File: rtl/bot_input_sequencer.sv
// Bot opponent input generator: on each accepted player-1 event it picks an
// action from a frame sample, an LFSR sample or the mirrored player input,
// waits a difficulty-scaled reaction delay, drives the command for a hold time
// and then sits out a cooldown before listening again.
module bot_input_sequencer #(
  parameter int          FRAME_MOD   = 120,
  parameter int          DELAY_STEP  = 7,
  parameter int          HOLD_STEP   = 4,
  parameter int          REACT_DELAY = 10,
  parameter int          COOLDOWN    = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                  clk_game,
  input logic                  reset_n,
  bot_input_sequencer_if.slave bus
);

  localparam logic [6:0]  FRAME_LAST    = 7'(FRAME_MOD - 1);
  localparam logic [7:0]  DELAY_STEP_B  = 8'(DELAY_STEP);
  localparam logic [7:0]  HOLD_STEP_B   = 8'(HOLD_STEP);
  localparam logic [7:0]  REACT_DELAY_B = 8'(REACT_DELAY);
  localparam logic [7:0]  COOLDOWN_LAST = 8'(COOLDOWN - 1);
  localparam bit          HAS_COOLDOWN  = (COOLDOWN != 0);
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [1:0]  MODE_LFSR     = 2'd1;
  localparam logic [1:0]  MODE_MIRROR   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DELAY,
    S_ACTION,
    S_COOLDOWN
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  frame_q, frame_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  diff_q, diff_d;
  // Only sample bits 5:0 feed the code/select decode, so the upper bits are not kept.
  logic [5:0]  sample_q, sample_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        right_q, right_d;
  logic        attack_q, attack_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;

  logic [2:0]  sample_code;
  logic [2:0]  sample_sel;
  logic [7:0]  sel_delay;
  logic [7:0]  sel_hold;
  logic        code_ok;

  assign sample_code = {sample_q[5], sample_q[3], sample_q[1]};
  assign sample_sel  = {sample_q[4], sample_q[2], sample_q[0]};
  assign sel_delay   = (8'(sample_sel) * DELAY_STEP_B) >> diff_q;
  assign sel_hold    = HOLD_STEP_B * (8'(sample_sel) + 8'd1);
  assign code_ok     = code_q inside {3'b100, 3'b001, 3'b010, 3'b110, 3'b011};

  // Free-running frame counter and Galois LFSR, both paused/cleared by enable.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    frame_d = frame_q;
    lfsr_d  = lfsr_q;
    if (lfsr_q == '0) begin
      lfsr_d = LFSR_SEED;
    end else if (bus.enable) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
    if (!bus.enable || frame_q == FRAME_LAST) begin
      frame_d = '0;
    end else begin
      frame_d = frame_q + 7'd1;
    end
  end

  // Sequencer next state: trigger latch, action decode, delay/hold/cooldown timing.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    diff_d   = diff_q;
    sample_d = sample_q;
    code_d   = code_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    right_d  = right_q;
    attack_d = attack_q;
    drop_d   = bus.p1_input_valid && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        {left_d, attack_d, right_d} = 3'b000;
        if (bus.p1_input_valid) begin
          mode_d = bus.mode;
          diff_d = bus.difficulty;
          case (bus.mode)
            MODE_LFSR:   sample_d = lfsr_q[5:0];
            MODE_MIRROR: sample_d = {3'b000, bus.p1_right, bus.p1_attack, bus.p1_left};
            default:     sample_d = frame_q[5:0];
          endcase
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (mode_q == MODE_MIRROR) begin
          code_d = sample_q[2:0];
          cnt_d  = REACT_DELAY_B >> diff_q;
          hold_d = HOLD_STEP_B;
        end else begin
          code_d = sample_code;
          cnt_d  = sel_delay;
          hold_d = sel_hold;
        end
        // Anything with attack in it is a single-cycle press.
        if (code_d[1]) begin
          hold_d = 8'd1;
        end
        state_d = S_DELAY;
      end
      S_DELAY: begin
        if (!code_ok) begin
          state_d = HAS_COOLDOWN ? S_COOLDOWN : S_IDLE;
          cnt_d   = COOLDOWN_LAST;
        end else if (cnt_q == '0) begin
          state_d                     = S_ACTION;
          cnt_d                       = hold_q - 8'd1;
          {left_d, attack_d, right_d} = code_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACTION: begin
        if (cnt_q == '0) begin
          {left_d, attack_d, right_d} = 3'b000;
          state_d = HAS_COOLDOWN ? S_COOLDOWN : S_IDLE;
          cnt_d   = COOLDOWN_LAST;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving bot mode abandons whatever was in flight.
    if (!bus.enable) begin
      state_d                     = S_IDLE;
      {left_d, attack_d, right_d} = 3'b000;
      drop_d                      = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset takes effect immediately.
  always_ff @(posedge clk_game or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      mode_q   <= '0;
      diff_q   <= '0;
      sample_q <= '0;
      code_q   <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      attack_q <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q  <= state_d;
      frame_q  <= frame_d;
      lfsr_q   <= lfsr_d;
      mode_q   <= mode_d;
      diff_q   <= diff_d;
      sample_q <= sample_d;
      code_q   <= code_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      right_q  <= right_d;
      attack_q <= attack_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.bot_left    = left_q;
  assign bus.bot_right   = right_q;
  assign bus.bot_attack  = attack_q;
  assign bus.bot_busy    = busy_q;
  assign bus.trig_drop   = drop_q;
  assign bus.frame_value = frame_q;

endmodule

// File: tb/tb_bot_input_sequencer.sv
// Scoreboard bench for bot_input_sequencer: stimulus predicts each accepted
// trigger's whole episode (busy window, command code, start and length) and
// each dropped trigger's pulse cycle; a monitor observes the DUT and compares.
module tb_bot_input_sequencer;
  localparam int          FRAME_MOD   = 120;
  localparam int          DELAY_STEP  = 7;
  localparam int          HOLD_STEP   = 4;
  localparam int          REACT_DELAY = 10;
  localparam int          COOLDOWN    = 8;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  logic clk_game = 1'b0;
  logic reset_n  = 1'b1;

  bot_input_sequencer_if bus ();

  bot_input_sequencer #(
    .FRAME_MOD  (FRAME_MOD),
    .DELAY_STEP (DELAY_STEP),
    .HOLD_STEP  (HOLD_STEP),
    .REACT_DELAY(REACT_DELAY),
    .COOLDOWN   (COOLDOWN),
    .LFSR_SEED  (LFSR_SEED)
  ) dut (
    .clk_game(clk_game),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_game = ~clk_game;

  // Number of rising edges seen so far; sampled on falling edges.
  int cyc = 0;
  always @(posedge clk_game) cyc <= cyc + 1;

  // Reference frame counter and LFSR.
  int          m_frame = 0;
  logic [15:0] m_lfsr  = LFSR_SEED;

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk_game or negedge reset_n) begin
    if (!reset_n) begin
      m_frame <= 0;
      m_lfsr  <= LFSR_SEED;
    end else begin
      m_frame <= bus.enable ? (m_frame + 1) % FRAME_MOD : 0;
      if (m_lfsr == 16'h0000) m_lfsr <= LFSR_SEED;
      else if (bus.enable)    m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  typedef struct {
    int rise;   // edge after which busy is high
    int code;   // {left,attack,right}, 0 when no command
    int start;  // edge after which the command appears, -1 if none
    int len;    // cycles the command is held
    int bend;   // edge after which busy is low again
  } txn_t;

  txn_t sb[$];
  int   drop_q[$];
  int   busy_end_last = -1;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic txn_t predict(int m, int d, int f, int l, bit pl, bit pr, bit pa, int t);
    int   s, code, sel, dly, hold;
    txn_t e;
    if (m == 2) begin
      code = pr * 4 + pa * 2 + pl;
      dly  = REACT_DELAY >> d;
      hold = HOLD_STEP;
    end else begin
      s    = (m == 1) ? (l & 255) : f;
      code = ((s >> 5) & 1) * 4 + ((s >> 3) & 1) * 2 + ((s >> 1) & 1);
      sel  = ((s >> 4) & 1) * 4 + ((s >> 2) & 1) * 2 + (s & 1);
      dly  = (sel * DELAY_STEP) >> d;
      hold = HOLD_STEP * (sel + 1);
    end
    e.rise = t;
    if (code == 4 || code == 1 || code == 2 || code == 6 || code == 3) begin
      if ((code & 2) != 0) hold = 1;
      e.code  = code;
      e.start = t + dly + 2;
      e.len   = hold;
      e.bend  = e.start + hold + COOLDOWN;
    end else begin
      e.code  = 0;
      e.start = -1;
      e.len   = 0;
      e.bend  = t + 2 + COOLDOWN;
    end
    return e;
  endfunction

  // Drive a one-cycle trigger from a falling edge and record what should follow.
  task automatic pulse(input int m, input int d, input bit pl, input bit pr, input bit pa);
    int   t;
    txn_t e;
    bus.mode           = 2'(m);
    bus.difficulty     = 2'(d);
    bus.p1_left        = pl;
    bus.p1_right       = pr;
    bus.p1_attack      = pa;
    bus.p1_input_valid = 1'b1;
    t = cyc + 1;
    if (t > busy_end_last) begin
      e = predict(m, d, m_frame, int'(m_lfsr), pl, pr, pa, t);
      sb.push_back(e);
      busy_end_last = e.bend;
    end else begin
      drop_q.push_back(t);
    end
    @(negedge clk_game);
    bus.p1_input_valid = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < busy_end_last) @(negedge clk_game);
  endtask

  task automatic wait_frame(input int f);
    for (int i = 0; i < 2 * FRAME_MOD && m_frame != f; i++) @(negedge clk_game);
    check("frame_at_trigger", int'(bus.frame_value), f);
  endtask

  task automatic fs_trigger(input int f, input int d);
    wait_idle();
    wait_frame(f);
    pulse(0, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic random_run(input int n, input int mode_fix);
    int m;
    for (int i = 0; i < n; i++) begin
      m = (mode_fix < 0) ? int'($urandom_range(0, 3)) : mode_fix;
      bus.mode       = 2'(m);
      bus.difficulty = 2'($urandom_range(0, 3));
      bus.p1_left    = 1'($urandom_range(0, 1));
      bus.p1_right   = 1'($urandom_range(0, 1));
      bus.p1_attack  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0)
        pulse(m, int'(bus.difficulty), bus.p1_left, bus.p1_right, bus.p1_attack);
      else
        @(negedge clk_game);
    end
  endtask

  // Monitor: reassembles each busy episode and compares it with the scoreboard.
  initial begin
    int   busy_prev, rise, code, start, len, shape_bad, prev_cmd, cur;
    txn_t e;
    busy_prev = 0; rise = 0; code = 0; start = -1; len = 0; shape_bad = 0; prev_cmd = 0;
    forever begin
      @(negedge clk_game);
      cur = int'({bus.bot_left, bus.bot_attack, bus.bot_right});
      if (!reset_n || !bus.enable) begin
        busy_prev = 0;
        prev_cmd  = 0;
        continue;
      end
      if (bus.trig_drop) begin
        if (drop_q.size() == 0) check("unexpected_trig_drop", 1, 0);
        else                    check("trig_drop_cycle", cyc, drop_q.pop_front());
      end
      if (bus.bot_busy && busy_prev == 0) begin
        rise = cyc; code = 0; start = -1; len = 0; shape_bad = 0;
      end
      if (cur != 0) begin
        if (!bus.bot_busy) check("cmd_without_busy", cur, 0);
        if (len == 0) begin
          code  = cur;
          start = cyc;
        end else if (cur != code || prev_cmd == 0) begin
          shape_bad = 1;
        end
        len++;
      end
      if (!bus.bot_busy && busy_prev != 0) begin
        if (sb.size() == 0) begin
          check("unexpected_busy_episode", 1, 0);
        end else begin
          e = sb.pop_front();
          check("busy_rise", rise, e.rise);
          check("cmd_code", code, e.code);
          check("cmd_start", start, e.start);
          check("cmd_len", len, e.len);
          check("cmd_shape", shape_bad, 0);
          check("busy_fall", cyc, e.bend);
        end
      end
      busy_prev = int'(bus.bot_busy);
      prev_cmd  = cur;
    end
  end

  initial begin
    int t, any;
    bus.enable = 1'b0; bus.mode = 2'd0; bus.difficulty = 2'd0;
    bus.p1_input_valid = 1'b0; bus.p1_left = 1'b0; bus.p1_right = 1'b0; bus.p1_attack = 1'b0;
    #1 reset_n = 1'b0;
    @(negedge clk_game);
    check("reset_busy", int'(bus.bot_busy), 0);
    check("reset_cmd", int'({bus.bot_left, bus.bot_attack, bus.bot_right}), 0);
    check("reset_drop", int'(bus.trig_drop), 0);
    check("reset_frame", int'(bus.frame_value), 0);
    @(negedge clk_game);
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    busy_end_last = cyc;

    // Frame counter wrap.
    for (int i = 0; i < 2 * FRAME_MOD && m_frame != FRAME_MOD - 1; i++) @(negedge clk_game);
    check("frame_before_wrap", int'(bus.frame_value), FRAME_MOD - 1);
    @(negedge clk_game);
    check("frame_after_wrap", int'(bus.frame_value), 0);

    // Directed frame-sample and mirror cases.
    fs_trigger(32, 0);   // left, sel 0
    fs_trigger(49, 0);   // left, sel 5, D=35, H=24
    fs_trigger(49, 2);   // D=8
    fs_trigger(8, 0);    // attack, one cycle
    fs_trigger(42, 0);   // invalid code 111
    wait_idle();
    pulse(2, 1, 1'b1, 1'b0, 1'b0);  // mirror of left is right, D=5, H=4

    // Retriggers during DELAY, inside COOLDOWN, on its last cycle, then first IDLE cycle.
    fs_trigger(49, 0);
    repeat (10) @(negedge clk_game);
    pulse(1, 3, 1'b1, 1'b1, 1'b1);
    while (cyc < busy_end_last - 3) @(negedge clk_game);
    pulse(0, 0, 1'b0, 1'b0, 1'b0);
    while (cyc < busy_end_last - 1) @(negedge clk_game);
    pulse(0, 0, 1'b0, 1'b0, 1'b0);
    pulse(2, 0, 1'b0, 1'b1, 1'b0);

    // enable low in the middle of DELAY: nothing may come out.
    fs_trigger(49, 0);
    repeat (5) @(negedge clk_game);
    bus.enable = 1'b0;
    sb.delete();
    drop_q.delete();
    @(negedge clk_game);
    check("disable_busy", int'(bus.bot_busy), 0);
    check("disable_cmd", int'({bus.bot_left, bus.bot_attack, bus.bot_right}), 0);
    check("disable_frame", int'(bus.frame_value), 0);
    bus.p1_input_valid = 1'b1;
    any = 0;
    repeat (40) begin
      @(negedge clk_game);
      if (bus.bot_left || bus.bot_right || bus.bot_attack || bus.bot_busy || bus.trig_drop) any = 1;
    end
    check("quiet_while_disabled", any, 0);
    bus.p1_input_valid = 1'b0;
    bus.enable = 1'b1;
    busy_end_last = cyc;

    // Asynchronous reset while the command is being held.
    fs_trigger(49, 2);
    t = cyc;
    while (cyc < t + 15) @(negedge clk_game);
    check("left_before_reset", int'(bus.bot_left), 1);
    #2 reset_n = 1'b0;
    sb.delete();
    drop_q.delete();
    #1;
    check("async_reset_cmd", int'({bus.bot_left, bus.bot_attack, bus.bot_right}), 0);
    check("async_reset_busy", int'(bus.bot_busy), 0);
    check("async_reset_frame", int'(bus.frame_value), 0);
    @(negedge clk_game);
    @(negedge clk_game);
    reset_n = 1'b1;
    busy_end_last = cyc;

    // Randomised traffic, a long idle stretch, then LFSR-sourced actions.
    random_run(3000, -1);
    repeat (20000) @(negedge clk_game);
    random_run(2000, 1);

    while (cyc <= busy_end_last + 2) @(negedge clk_game);
    check("episodes_outstanding", sb.size(), 0);
    check("drops_outstanding", drop_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
